// File: rtl/uart_frame_decoder.sv
// uart_frame_decoder: parses SOF/LEN/payload/CHK frames from a UART byte stream,
// buffers the payload and drains it over a valid/ready handshake once the checksum matches.
module uart_frame_decoder #(
    parameter int         MAX_LEN = 16,
    parameter logic [7:0] SOF     = 8'hA5,
    parameter int         TIMEOUT = 10000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_frame_error,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       pkt_ok,
    output logic       chk_err,
    output logic       len_err,
    output logic       rx_err,
    output logic       timeout,
    output logic       overrun,
    output logic       busy
);
    localparam int PW = $clog2(MAX_LEN + 1);
    localparam int AW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [2:0] HUNT = 3'd0, GET_LEN = 3'd1, PAYLOAD = 3'd2, GET_CHK = 3'd3, DRAIN = 3'd4;
    logic [2:0]    state;
    logic [7:0]    len;
    logic [7:0]    chk;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [TW-1:0] idle;
    logic [7:0]    buffer [0:(1<<AW)-1];
    logic          active;
    logic          idle_out;
    logic          last_in;
    assign active    = state == GET_LEN || state == PAYLOAD || state == GET_CHK;
    assign idle_out  = active && !rx_valid && idle == TW'(TIMEOUT - 1);
    assign last_in   = 8'(wr_ptr) + 8'd1 == len;
    assign out_valid = state == DRAIN;
    assign out_data  = out_valid ? buffer[rd_ptr[AW-1:0]] : 8'd0;
    assign out_last  = out_valid && 8'(rd_ptr) == len - 8'd1;
    assign busy      = state != HUNT;
    // Payload storage carries no reset so it can map onto plain RAM
    always_ff @(posedge clk)
        if (state == PAYLOAD && rx_valid && !rx_frame_error) buffer[wr_ptr[AW-1:0]] <= rx_data;
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= HUNT;
            len     <= '0;
            chk     <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            idle    <= '0;
            {pkt_ok, chk_err, len_err, rx_err, timeout, overrun} <= '0;
        end else begin
            {pkt_ok, chk_err, len_err, rx_err, timeout, overrun} <= '0;
            idle <= (active && !rx_valid) ? idle + TW'(1) : '0;
            if (idle_out) begin
                timeout <= 1'b1;
                state   <= HUNT;
            end else if (rx_valid) begin
                case (state)
                    HUNT: if (rx_data == SOF && !rx_frame_error) begin
                        state  <= GET_LEN;
                        wr_ptr <= '0;
                        rd_ptr <= '0;
                        chk    <= '0;
                    end
                    GET_LEN, PAYLOAD, GET_CHK: if (rx_frame_error) begin
                        rx_err <= 1'b1;
                        state  <= HUNT;
                    end else if (state == GET_LEN) begin
                        len <= rx_data;
                        chk <= rx_data;
                        if (rx_data == 8'd0) state <= GET_CHK;
                        else if (rx_data > 8'(MAX_LEN)) begin
                            len_err <= 1'b1;
                            state   <= HUNT;
                        end else state <= PAYLOAD;
                    end else if (state == PAYLOAD) begin
                        wr_ptr <= wr_ptr + PW'(1);
                        chk    <= chk ^ rx_data;
                        if (last_in) state <= GET_CHK;
                    end else if (rx_data == chk) begin
                        pkt_ok <= 1'b1;
                        rd_ptr <= '0;
                        state  <= len == 8'd0 ? HUNT : DRAIN;
                    end else begin
                        chk_err <= 1'b1;
                        state   <= HUNT;
                    end
                    DRAIN: overrun <= 1'b1;
                    default: state <= HUNT;
                endcase
            end
            if (out_valid && out_ready) begin
                rd_ptr <= rd_ptr + PW'(1);
                if (out_last) state <= HUNT;
            end
        end
    end
endmodule

// File: tb/tb_uart_frame_decoder.sv
// tb_uart_frame_decoder: directed and randomized frames checked against a
// frame-parsing reference model; a negedge monitor collects output bytes and pulses.
module tb_uart_frame_decoder;
    localparam int         MAXL = 16;
    localparam logic [7:0] SOF  = 8'hA5;
    localparam int         TO   = 40;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'd0;
    logic       rx_valid = 1'b0;
    logic       rx_frame_error = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_valid, out_last, pkt_ok, chk_err, len_err, rx_err, timeout, overrun, busy;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cnt_ok, cnt_chk, cnt_len, cnt_rx, cnt_to, cnt_ov, n_valid, last_idx;
    logic [7:0] got[$];
    int xfer_cyc[$];
    logic [7:0] tx_b[$];
    logic tx_fe[$];
    logic [7:0] exp_q[$];
    int exp_st;
    logic prev_stall = 1'b0, prev_last = 1'b0, prev_lastx = 1'b0;
    logic [7:0] prev_data = 8'd0;

    uart_frame_decoder #(.MAX_LEN(MAXL), .SOF(SOF), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_frame_error(rx_frame_error), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .pkt_ok(pkt_ok), .chk_err(chk_err),
        .len_err(len_err), .rx_err(rx_err), .timeout(timeout), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        int np;
        cyc++;
        np = int'(pkt_ok) + int'(chk_err) + int'(len_err) + int'(rx_err) + int'(timeout) + int'(overrun);
        if (np != 0) chk("pulse_exclusive", np, 1);
        cnt_ok += int'(pkt_ok); cnt_chk += int'(chk_err); cnt_len += int'(len_err);
        cnt_rx += int'(rx_err); cnt_to += int'(timeout); cnt_ov += int'(overrun);
        if (out_valid) n_valid++;
        if (prev_stall && out_valid) begin
            chk("hold_data", out_data, prev_data);
            chk("hold_last", out_last, prev_last);
        end
        if (prev_lastx) chk("valid_after_last", out_valid, 0);
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
        prev_lastx = out_valid && out_ready && out_last;
        if (out_valid && out_ready) begin
            got.push_back(out_data);
            xfer_cyc.push_back(cyc);
            if (out_last) last_idx = got.size() - 1;
        end
    end

    task automatic clear_mon;
        cnt_ok = 0; cnt_chk = 0; cnt_len = 0; cnt_rx = 0; cnt_to = 0; cnt_ov = 0;
        n_valid = 0; last_idx = -1;
        got.delete(); xfer_cyc.delete();
    endtask

    task automatic push(input logic [7:0] b);
        tx_b.push_back(b);
        tx_fe.push_back(1'b0);
    endtask

    task automatic load(input logic [7:0] a [$]);
        tx_b.delete(); tx_fe.delete();
        foreach (a[i]) push(a[i]);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic fe);
        rx_data = b; rx_valid = 1'b1; rx_frame_error = fe;
        @(posedge clk); #1;
        rx_valid = 1'b0; rx_frame_error = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_all(input int gmax);
        foreach (tx_b[i]) begin
            send_byte(tx_b[i], tx_fe[i]);
            if (gmax > 0) idle($urandom_range(0, gmax));
        end
    endtask

    // Reference: walk the byte stream by the frame rules and decide outcome and payload
    task automatic model;
        int i, n, l;
        logic [7:0] x;
        exp_q.delete(); exp_st = 0; n = tx_b.size(); i = 0;
        while (i < n && (tx_b[i] != SOF || tx_fe[i])) i++;
        i++;
        if (i >= n) return;
        if (tx_fe[i]) begin exp_st = 4; return; end
        l = int'(tx_b[i]); i++;
        if (l > MAXL) begin exp_st = 3; return; end
        x = 8'(l);
        for (int k = 0; k < l; k++) begin
            if (i >= n) return;
            if (tx_fe[i]) begin exp_st = 4; exp_q.delete(); return; end
            exp_q.push_back(tx_b[i]);
            x ^= tx_b[i];
            i++;
        end
        if (i >= n) return;
        exp_st = tx_fe[i] ? 4 : (tx_b[i] == x ? 1 : 2);
        if (exp_st != 1) exp_q.delete();
    endtask

    task automatic drain(input bit rnd);
        for (int c = 0; c < 200 && busy; c++) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
        end
        chk("drained_busy", busy, 0);
        out_ready = 1'b1;
        @(negedge clk); #1;
    endtask

    task automatic expect_status(input int st, input int ov);
        chk("pkt_ok_cnt", cnt_ok, st == 1);
        chk("chk_err_cnt", cnt_chk, st == 2);
        chk("len_err_cnt", cnt_len, st == 3);
        chk("rx_err_cnt", cnt_rx, st == 4);
        chk("timeout_cnt", cnt_to, 0);
        chk("overrun_cnt", cnt_ov, ov);
    endtask

    task automatic expect_payload;
        chk("n_bytes", got.size(), exp_q.size());
        foreach (exp_q[i]) if (i < got.size()) chk("payload", got[i], exp_q[i]);
        if (exp_q.size() > 0) chk("last_idx", last_idx, exp_q.size() - 1);
        else chk("no_out_valid", n_valid, 0);
    endtask

    task automatic run(input int gmax, input bit rnd);
        clear_mon();
        out_ready = 1'b1;
        send_all(gmax);
        model();
        drain(rnd);
        expect_status(exp_st, 0);
        expect_payload();
    endtask

    initial begin
        int n, g, l, j;
        logic [7:0] x, b;
        logic seen;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_pulses", {pkt_ok, chk_err, len_err, rx_err, timeout, overrun}, 0);
        reset = 1'b0;
        idle(1);

        load('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03});
        run(0, 0);
        chk("good_ok", cnt_ok, 1);
        chk("good_b2", got.size() == 3 ? got[2] : 8'hxx, 8'h33);
        chk("good_consec", xfer_cyc.size() == 3 ? xfer_cyc[2] - xfer_cyc[0] : -1, 2);

        load('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04});
        run(0, 0);
        chk("bad_chk_err", cnt_chk, 1);
        chk("bad_no_valid", n_valid, 0);
        load('{8'hA5, 8'h01, 8'h7E, 8'h7F});
        run(0, 0);
        chk("after_bad_ok", cnt_ok, 1);

        load('{8'hA5, 8'h00, 8'h00});
        run(0, 0);
        chk("zero_ok", cnt_ok, 1);
        chk("zero_no_valid", n_valid, 0);
        load('{8'hA5, 8'h11});
        run(0, 0);
        chk("long_len_err", cnt_len, 1);

        clear_mon();
        load('{8'hA5, 8'h02, 8'h11});
        send_all(0);
        n = 0; seen = 1'b0;
        while (!seen && n < TO + 10) begin
            @(posedge clk); n++;
            @(negedge clk); seen = timeout;
        end
        #1;
        chk("timeout_delay", n, TO);
        chk("timeout_busy", busy, 0);

        load('{8'hA5, 8'h11});
        tx_fe[1] = 1'b1;
        run(0, 0);
        chk("fe_rx_err", cnt_rx, 1);

        clear_mon();
        out_ready = 1'b0;
        load('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03});
        send_all(0);
        model();
        idle(5); send_byte(8'h5A, 1'b0); idle(6); send_byte(SOF, 1'b0); idle(7);
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, 8'h11);
        chk("stall_last", out_last, 0);
        drain(0);
        expect_status(1, 2);
        expect_payload();

        clear_mon();
        out_ready = 1'b0;
        send_all(0);
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        chk("pre_rst_xfer", got.size(), 1);
        reset = 1'b1;
        idle(1);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_pulses", {pkt_ok, chk_err, len_err, rx_err, timeout, overrun}, 0);
        reset = 1'b0;
        out_ready = 1'b1;
        idle(1);
        load('{8'hA5, 8'h02, 8'hDE, 8'hAD, 8'h71});
        run(0, 0);
        chk("post_rst_ok", cnt_ok, 1);

        for (int it = 0; it < 40; it++) begin
            tx_b.delete(); tx_fe.delete();
            g = $urandom_range(0, 2);
            repeat (g) begin
                b = 8'($urandom_range(0, 255));
                push(b == SOF ? 8'h00 : b);
            end
            push(SOF);
            l = $urandom_range(0, 20);
            push(8'(l));
            if (l <= MAXL) begin
                x = 8'(l);
                repeat (l) begin
                    b = 8'($urandom_range(0, 255));
                    x ^= b;
                    push(b);
                end
                push(($urandom_range(0, 3) == 0) ? x ^ 8'(1 << $urandom_range(0, 7)) : x);
            end
            if ($urandom_range(0, 7) == 0) begin
                j = $urandom_range(g + 1, tx_b.size() - 1);
                tx_fe[j] = 1'b1;
                while (tx_b.size() > j + 1) begin
                    void'(tx_b.pop_back());
                    void'(tx_fe.pop_back());
                end
            end
            run(2, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
